spi_xfer_sequencer: RTL and testbench

- Upstream companion of spi_controller. Turns a multi-byte SPI transaction into a sequence of single-byte start/busy handshakes on the byte-level controller.
- Owns chip-select timing: setup, hold and inter-transaction gap.
- Streams TX bytes in and RX bytes out over valid/ready interfaces.

---
 rtl/spi_xfer_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI transaction sequencer: owns chip-select setup/hold/gap timing
// and feeds single bytes to a byte-level spi_controller via start/busy handshakes.
module spi_xfer_sequencer #(
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int CS_GAP    = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_len,
    input  logic       cmd_keep_cs,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       cs_n,
    output logic       byte_start,
    output logic [7:0] byte_tx_data,
    input  logic [7:0] byte_rx_data,
    input  logic       byte_busy
);

    // Valid/ready: a transfer happens on a rising clk edge where both are high;
    // a source holds valid and its data stable until that edge.

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RX_PUSH,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [CNT_WIDTH-1:0] SETUP_INIT = CNT_WIDTH'(CS_SETUP - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_INIT  = CNT_WIDTH'(CS_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_INIT   = CNT_WIDTH'(CS_GAP - 1);
    localparam logic [CNT_WIDTH-1:0] TIMER_ZERO = '0;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] timer_q, timer_d;
    logic [7:0]           remaining_q, remaining_d;
    logic                 keep_q, keep_d;
    logic                 cs_kept_q, cs_kept_d;
    logic                 cs_n_q, cs_n_d;
    logic                 byte_start_q, byte_start_d;
    logic [7:0]           byte_tx_data_q, byte_tx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           rx_data_q, rx_data_d;

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        remaining_d    = remaining_q;
        keep_d         = keep_q;
        cs_kept_d      = cs_kept_q;
        cs_n_d         = cs_n_q;
        byte_start_d   = 1'b0;
        byte_tx_data_d = byte_tx_data_q;
        rx_valid_d     = rx_valid_q;
        rx_data_d      = rx_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    remaining_d = cmd_len;
                    keep_d      = cmd_keep_cs;
                    // A chained command finds cs_n already low and skips setup.
                    if (cs_kept_q) begin
                        state_d = S_LOAD;
                    end else begin
                        cs_n_d  = 1'b0;
                        timer_d = SETUP_INIT;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (timer_q == TIMER_ZERO) begin
                    state_d = S_LOAD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_LOAD: begin
                if (tx_valid) begin
                    byte_tx_data_d = tx_data;
                    state_d        = S_START;
                end
            end
            S_START: begin
                if (!byte_busy) begin
                    byte_start_d = 1'b1;
                    state_d      = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (byte_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!byte_busy) begin
                    rx_data_d  = byte_rx_data;
                    rx_valid_d = 1'b1;
                    state_d    = S_RX_PUSH;
                end
            end
            S_RX_PUSH: begin
                // The next byte is only loaded after the RX byte is taken.
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    if (remaining_q != 8'd0) begin
                        remaining_d = remaining_q - 8'd1;
                        state_d     = S_LOAD;
                    end else if (keep_q) begin
                        cs_kept_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        timer_d = HOLD_INIT;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (timer_q == TIMER_ZERO) begin
                    cs_n_d    = 1'b1;
                    cs_kept_d = 1'b0;
                    timer_d   = GAP_INIT;
                    state_d   = S_GAP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == TIMER_ZERO) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            remaining_q    <= 8'd0;
            keep_q         <= 1'b0;
            cs_kept_q      <= 1'b0;
            cs_n_q         <= 1'b1;
            byte_start_q   <= 1'b0;
            byte_tx_data_q <= 8'd0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            remaining_q    <= remaining_d;
            keep_q         <= keep_d;
            cs_kept_q      <= cs_kept_d;
            cs_n_q         <= cs_n_d;
            byte_start_q   <= byte_start_d;
            byte_tx_data_q <= byte_tx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign tx_ready     = (state_q == S_LOAD);
    assign busy         = (state_q != S_IDLE);
    assign cs_n         = cs_n_q;
    assign byte_start   = byte_start_q;
    assign byte_tx_data = byte_tx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: byte-controller model, directed drivers and
// queue-based monitors for TX bytes started and RX bytes delivered.
module tb_spi_xfer_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic       cmd_keep_cs;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       busy;
    logic       cs_n;
    logic       byte_start;
    logic [7:0] byte_tx_data;
    logic [7:0] byte_rx_data;
    logic       byte_busy;

    spi_xfer_sequencer #(
        .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(2), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_keep_cs(cmd_keep_cs),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .busy(busy), .cs_n(cs_n),
        .byte_start(byte_start), .byte_tx_data(byte_tx_data),
        .byte_rx_data(byte_rx_data), .byte_busy(byte_busy)
    );

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    int chk_cnt = 0;
    int pass_cnt = 0;
    int start_cnt = 0;
    int rx_cnt = 0;
    int cs_rise_cnt = 0;
    logic cs_n_prev = 1'b1;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- byte controller model ----------------
    // Busy for three cycles after each start; returns tx ^ 8'h99.
    initial begin
        logic [7:0] cap;
        byte_busy    = 1'b0;
        byte_rx_data = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (byte_start && !rst) begin
                cap       = byte_tx_data;
                byte_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                byte_rx_data = cap ^ 8'h99;
                byte_busy    = 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (byte_start) begin
                    start_cnt++;
                    chk("start_cs_low", cs_n, 1'b0);
                    chk("start_no_rx_pending", rx_valid, 1'b0);
                    if (tx_exp_q.size() == 0) chk("start_unexpected", 1, 0);
                    else begin
                        e = tx_exp_q.pop_front();
                        chk("byte_tx_data", byte_tx_data, e);
                    end
                end
                if (rx_valid && rx_ready) begin
                    rx_cnt++;
                    if (rx_exp_q.size() == 0) chk("rx_unexpected", 1, 0);
                    else begin
                        e = rx_exp_q.pop_front();
                        chk("rx_data", rx_data, e);
                    end
                end
                if (cs_n && !cs_n_prev) cs_rise_cnt++;
            end
            cs_n_prev = cs_n;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [7:0] len, input logic keep);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 0, 1);
            return;
        end
        cmd_valid   = 1'b1;
        cmd_len     = len;
        cmd_keep_cs = keep;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        cmd_len     = 8'hxx;
        cmd_keep_cs = 1'b0;
    endtask

    task automatic send_tx(input logic [7:0] data, input logic [7:0] exp_rx, input int stall);
        int t = 0;
        while (!tx_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!tx_ready) begin
            chk("tx_ready_timeout", 0, 1);
            return;
        end
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall_no_start", byte_start, 1'b0);
            chk("stall_tx_ready", tx_ready, 1'b1);
        end
        tx_valid = 1'b1;
        tx_data  = data;
        @(posedge clk);
        tx_exp_q.push_back(data);
        rx_exp_q.push_back(exp_rx);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'hxx;
    endtask

    task automatic recv_rx(input int n, input int stall_idx, input int stall_len,
                           input logic [7:0] stall_val);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!rx_valid && t < 200) begin
                @(posedge clk); #1; t++;
            end
            if (!rx_valid) begin
                chk("rx_valid_timeout", 0, 1);
                return;
            end
            if (i == stall_idx) begin
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    chk("bp_rx_valid", rx_valid, 1'b1);
                    chk("bp_rx_data", rx_data, stall_val);
                    chk("bp_no_start", byte_start, 1'b0);
                end
            end
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
        end
    endtask

    task automatic count_until_cs_high(output int k);
        k = 0;
        while (!cs_n && k < 100) begin
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic count_until_cmd_ready(output int k);
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
    endtask

    // Single byte with full chip-select timing checks.
    task automatic run_single(input logic [7:0] d, input logic [7:0] r);
        int k;
        int s0;
        s0 = start_cnt;
        send_cmd(8'd0, 1'b0);
        chk("cs_low_on_accept", cs_n, 1'b0);
        k = 0;
        while (!tx_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        chk("setup_cycles", k, 4);
        fork
            send_tx(d, r, 0);
            recv_rx(1, -1, 0, 8'd0);
        join
        count_until_cs_high(k);
        chk("hold_cycles", k, 4);
        count_until_cmd_ready(k);
        chk("gap_cycles", k, 2);
        chk("single_start_count", start_cnt - s0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        int s0;
        int r0;
        int c0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_len = 8'd0; cmd_keep_cs = 1'b0;
        tx_valid = 1'b0; tx_data = 8'd0; rx_ready = 1'b0;
        #12;
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_byte_start", byte_start, 1'b0);
        chk("rst_rx_data", rx_data, 8'd0);
        chk("rst_byte_tx_data", byte_tx_data, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);

        // single byte
        run_single(8'hA5, 8'h3C);

        // three bytes with a TX stall before byte 2
        s0 = start_cnt; r0 = cs_rise_cnt;
        send_cmd(8'd2, 1'b0);
        fork
            begin
                send_tx(8'h01, 8'h98, 0);
                send_tx(8'h02, 8'h9B, 5);
                send_tx(8'h03, 8'h9A, 0);
            end
            recv_rx(3, -1, 0, 8'd0);
        join
        chk("three_cs_still_low", cs_n, 1'b0);
        count_until_cmd_ready(k);
        chk("three_start_count", start_cnt - s0, 3);
        chk("three_cs_rises", cs_rise_cnt - r0, 1);

        // RX backpressure on byte 1 of 2
        s0 = start_cnt; c0 = rx_cnt;
        send_cmd(8'd1, 1'b0);
        fork
            begin
                send_tx(8'h5A, 8'hC3, 0);
                send_tx(8'hC3, 8'h5A, 0);
            end
            recv_rx(2, 0, 10, 8'hC3);
        join
        count_until_cmd_ready(k);
        chk("bp_start_count", start_cnt - s0, 2);
        chk("bp_rx_count", rx_cnt - c0, 2);

        // chaining: keep cs low across two commands
        r0 = cs_rise_cnt;
        send_cmd(8'd0, 1'b1);
        fork
            send_tx(8'h11, 8'h88, 0);
            recv_rx(1, -1, 0, 8'd0);
        join
        chk("chain_idle_ready", cmd_ready, 1'b1);
        chk("chain_cs_kept_low", cs_n, 1'b0);
        send_cmd(8'd1, 1'b0);
        chk("chain_skip_setup", tx_ready, 1'b1);
        fork
            begin
                send_tx(8'h22, 8'hBB, 0);
                send_tx(8'h33, 8'hAA, 0);
            end
            recv_rx(2, -1, 0, 8'd0);
        join
        chk("chain_no_rise_before_hold", cs_rise_cnt - r0, 0);
        count_until_cs_high(k);
        chk("chain_hold_cycles", k, 4);
        count_until_cmd_ready(k);
        chk("chain_cs_rises", cs_rise_cnt - r0, 1);

        // reset asserted in WAIT_DONE
        send_cmd(8'd0, 1'b0);
        send_tx(8'h77, 8'hEE, 0);
        k = 0;
        while (!byte_busy && k < 100) begin
            @(posedge clk); #1; k++;
        end
        chk("rst_test_busy_seen", byte_busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", cs_n, 1'b1);
        chk("midrst_byte_start", byte_start, 1'b0);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        tx_exp_q.delete();
        rx_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        while (byte_busy && k < 100) begin
            @(posedge clk); #1; k++;
        end
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        run_single(8'h5A, 8'hC3);

        // maximum length: 256 bytes
        s0 = start_cnt; c0 = rx_cnt;
        send_cmd(8'd255, 1'b0);
        fork
            for (int i = 0; i < 256; i++) begin
                logic [7:0] b;
                b = 8'(i);
                send_tx(b, b ^ 8'h99, 0);
            end
            recv_rx(256, -1, 0, 8'd0);
        join
        count_until_cs_high(k);
        chk("max_hold_cycles", k, 4);
        count_until_cmd_ready(k);
        chk("max_gap_cycles", k, 2);
        chk("max_start_count", start_cnt - s0, 256);
        chk("max_rx_count", rx_cnt - c0, 256);
        chk("max_queues_drained", tx_exp_q.size() + rx_exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
